// File: rtl/perceptron_trainer_pkg.sv
// perceptron_trainer_pkg: shared types and saturating arithmetic for the perceptron trainer
package perceptron_trainer_pkg;
  typedef enum logic [1:0] {Linear, ReLU, Sigmoid, Step} Act_Func;
  typedef enum logic [2:0] {TR_IDLE, TR_ACCEPT, TR_WAIT, TR_UPDATE, TR_DONE} tr_state_e;
  function automatic int sat_add(int a, int d, int width);
    int hi, lo, s;
    hi = (1 << (width - 1)) - 1;
    lo = -(1 << (width - 1));
    s = a + d;
    return s > hi ? hi : s < lo ? lo : s;
  endfunction
endpackage

// File: rtl/perceptron_trainer_if.sv
// perceptron_trainer_if: labelled-sample valid/ready stream into the trainer
interface perceptron_trainer_if #(parameter int SIZE = 2);
  logic s_valid;
  logic s_ready;
  logic [SIZE-1:0] s_values;
  logic s_target;
  logic s_last;
  modport master(output s_valid, s_values, s_target, s_last, input s_ready);
  modport slave(input s_valid, s_values, s_target, s_last, output s_ready);
endinterface

// File: rtl/perceptron_trainer_weight_lane.sv
// weight_lane: one signed saturating weight register updated by the perceptron rule
module weight_lane
  import perceptron_trainer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LR_SHIFT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic signed [1:0] err,
  output logic signed [WIDTH-1:0] w
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) w <= '0;
    else if (clr) w <= '0;
    else if (en && err != 2'sd0) w <= WIDTH'(sat_add(int'(w), int'(err) <<< LR_SHIFT, WIDTH));
endmodule

// File: rtl/perceptron_trainer.sv
// perceptron_trainer: epoch-based online perceptron-rule trainer driving a Perceptron instance
module perceptron_trainer
  import perceptron_trainer_pkg::*;
#(
  parameter int SIZE = 2,
  parameter int WIDTH = 8,
  parameter int LR_SHIFT = 0,
  parameter int PRED_LAT = 1,
  parameter int MAX_EPOCHS = 16,
  parameter Act_Func ACT = ReLU,
  localparam int EW = $clog2(MAX_EPOCHS + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  perceptron_trainer_if.slave s,
  output logic [(SIZE+1)*WIDTH-1:0] p_weights,
  output logic [SIZE:0] p_values,
  output logic p_bias,
  output Act_Func p_activation,
  input  logic p_prediction,
  output logic busy,
  output logic done,
  output logic converged,
  output logic [EW-1:0] epoch_cnt,
  output logic [15:0] err_cnt
);
  localparam int CW = PRED_LAT > 1 ? $clog2(PRED_LAT) : 1;
  tr_state_e state, nxt;
  logic t_q, last_q, go, hs, upd, zero_ep, lim;
  logic [CW-1:0] wcnt;
  logic signed [1:0] err;
  always_comb begin
    go = start && (state == TR_IDLE || state == TR_DONE);
    hs = s.s_valid && state == TR_ACCEPT;
    upd = state == TR_UPDATE;
    err = $signed({1'b0, t_q}) - $signed({1'b0, p_prediction});
    zero_ep = err_cnt == 16'd0 && err == 2'sd0;
    lim = epoch_cnt == EW'(MAX_EPOCHS - 1);
    nxt = state;
    case (state)
      TR_IDLE, TR_DONE: nxt = go ? TR_ACCEPT : state;
      TR_ACCEPT: nxt = hs ? TR_WAIT : state;
      TR_WAIT: nxt = wcnt == CW'(PRED_LAT - 1) ? TR_UPDATE : state;
      TR_UPDATE: nxt = last_q && (zero_ep || lim) ? TR_DONE : TR_ACCEPT;
      default: nxt = TR_IDLE;
    endcase
  end
  assign s.s_ready = state == TR_ACCEPT;
  assign busy = state != TR_IDLE && state != TR_DONE;
  assign done = state == TR_DONE;
  assign p_bias = 1'b1;
  assign p_activation = ACT;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= TR_IDLE;
      p_values <= '0;
      t_q <= 1'b0;
      last_q <= 1'b0;
      wcnt <= '0;
      epoch_cnt <= '0;
      err_cnt <= '0;
      converged <= 1'b0;
    end else begin
      state <= nxt;
      if (go) begin
        epoch_cnt <= '0;
        err_cnt <= '0;
        converged <= 1'b0;
      end
      if (hs) begin
        p_values <= {1'b1, s.s_values};
        t_q <= s.s_target;
        last_q <= s.s_last;
        wcnt <= '0;
      end
      if (state == TR_WAIT) wcnt <= wcnt + 1'b1;
      if (upd) begin
        if (last_q) epoch_cnt <= epoch_cnt + 1'b1;
        if (last_q && zero_ep) converged <= 1'b1;
        // a failed, non-final epoch restarts the error tally; the final one keeps it
        err_cnt <= last_q && !zero_ep && !lim ? 16'd0 :
                   err != 2'sd0 && err_cnt != 16'hFFFF ? err_cnt + 16'd1 : err_cnt;
      end
    end
  for (genvar i = 0; i <= SIZE; i++) begin : g_lane
    weight_lane #(.WIDTH(WIDTH), .LR_SHIFT(LR_SHIFT)) u_lane (
      .clk(clk),
      .rst_n(rst_n),
      .clr(go),
      .en(upd && p_values[i]),
      .err(err),
      .w(p_weights[i*WIDTH +: WIDTH])
    );
  end
endmodule

// File: tb/tb_perceptron_trainer.sv
// tb_perceptron_trainer: directed checks of three trainer configurations with stubbed predictions
module tb_perceptron_trainer;
  import perceptron_trainer_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic valid[3], tgt[3], last[3], pred[3], rdy[3];
  logic [1:0] vals[3];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  perceptron_trainer_if #(.SIZE(2)) ia ();
  perceptron_trainer_if #(.SIZE(2)) ib ();
  perceptron_trainer_if #(.SIZE(2)) ic ();
  assign ia.s_valid = valid[0];
  assign ia.s_values = vals[0];
  assign ia.s_target = tgt[0];
  assign ia.s_last = last[0];
  assign rdy[0] = ia.s_ready;
  assign ib.s_valid = valid[1];
  assign ib.s_values = vals[1];
  assign ib.s_target = tgt[1];
  assign ib.s_last = last[1];
  assign rdy[1] = ib.s_ready;
  assign ic.s_valid = valid[2];
  assign ic.s_values = vals[2];
  assign ic.s_target = tgt[2];
  assign ic.s_last = last[2];
  assign rdy[2] = ic.s_ready;
  logic [23:0] wa, wc;
  logic [15:0] wb;
  logic [2:0] pva, pvb, pvc;
  logic bia, bib, bic, bsa, bsb, bsc, dna, dnb, dnc, cva, cvb, cvc;
  Act_Func aca, acb, acc;
  logic [4:0] epa, epb;
  logic [1:0] epc;
  logic [15:0] eca, ecb, ecc;
  perceptron_trainer dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .s(ia), .p_weights(wa), .p_values(pva),
    .p_bias(bia), .p_activation(aca), .p_prediction(pred[0]), .busy(bsa), .done(dna),
    .converged(cva), .epoch_cnt(epa), .err_cnt(eca));
  perceptron_trainer #(.WIDTH(4), .LR_SHIFT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .s(ib), .p_weights(wb), .p_values(pvb),
    .p_bias(bib), .p_activation(acb), .p_prediction(pred[1]), .busy(bsb), .done(dnb),
    .converged(cvb), .epoch_cnt(epb), .err_cnt(ecb));
  perceptron_trainer #(.MAX_EPOCHS(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start), .s(ic), .p_weights(wc), .p_values(pvc),
    .p_bias(bic), .p_activation(acc), .p_prediction(pred[2]), .busy(bsc), .done(dnc),
    .converged(cvc), .epoch_cnt(epc), .err_cnt(ecc));
  typedef struct {
    bit rs;
    logic [1:0] x;
    bit t, p, l;
    int w0, w1, wb, ec, dn, cv, ep;
  } vec_t;
  vec_t tv[8];
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", n, act, exp);
    end
  endtask
  task automatic rst_start();
    @(negedge clk);
    for (int d = 0; d < 3; d++) valid[d] = 1'b0;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("ready_after_start", int'(rdy[0]), 1);
  endtask
  task automatic send(input int d, input logic [1:0] x, input logic t, input logic p, input logic l);
    int n;
    @(negedge clk);
    vals[d] = x;
    tgt[d] = t;
    pred[d] = p;
    last[d] = l;
    valid[d] = 1'b1;
    n = 0;
    while (!rdy[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[d]) begin
      chk("ready_timeout", 0, 1);
      valid[d] = 1'b0;
    end else begin
      @(posedge clk);
      #1 valid[d] = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int eb[8];
    for (int d = 0; d < 3; d++) begin
      valid[d] = 1'b0; tgt[d] = 1'b0; last[d] = 1'b0; pred[d] = 1'b0; vals[d] = 2'b00;
    end
    tv[0] = '{1, 2'b11, 1, 0, 0, 1, 1, 1, 1, 0, 0, 0};
    tv[1] = '{1, 2'b01, 0, 1, 0, -1, 0, -1, 1, 0, 0, 0};
    tv[2] = '{0, 2'b00, 1, 1, 0, -1, 0, -1, 1, 0, 0, 0};
    tv[3] = '{1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[4] = '{0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[5] = '{0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[6] = '{0, 2'b11, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1};
    tv[7] = '{1, 2'b11, 1, 0, 1, 1, 1, 1, 0, 0, 0, 1};
    #12;
    chk("reset_weights", int'(wa), 0);
    chk("reset_ready", int'(rdy[0]), 0);
    chk("reset_done", int'(dna), 0);
    chk("reset_busy", int'(bsa), 0);
    chk("reset_values", int'(pva), 0);
    chk("bias_const", int'(bia), 1);
    chk("activation", int'(aca), int'(ReLU));
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (tv[i].rs) rst_start();
      send(0, tv[i].x, tv[i].t, tv[i].p, tv[i].l);
      chk($sformatf("v%0d_w0", i), int'($signed(wa[7:0])), tv[i].w0);
      chk($sformatf("v%0d_w1", i), int'($signed(wa[15:8])), tv[i].w1);
      chk($sformatf("v%0d_wb", i), int'($signed(wa[23:16])), tv[i].wb);
      chk($sformatf("v%0d_err", i), int'(eca), tv[i].ec);
      chk($sformatf("v%0d_done", i), int'(dna), tv[i].dn);
      chk($sformatf("v%0d_conv", i), int'(cva), tv[i].cv);
      chk($sformatf("v%0d_epoch", i), int'(epa), tv[i].ep);
    end
    @(negedge clk);
    vals[0] = 2'b11; tgt[0] = 1'b1; pred[0] = 1'b0; last[0] = 1'b0; valid[0] = 1'b1;
    @(posedge clk);
    #1 valid[0] = 1'b0;
    chk("wait_entered", int'(bsa & ~rdy[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_weights", int'(wa), 0);
    chk("midrst_ready", int'(rdy[0]), 0);
    chk("midrst_done", int'(dna), 0);
    chk("midrst_busy", int'(bsa), 0);
    chk("midrst_values", int'(pva), 0);
    rst_n = 1'b1;
    rst_start();
    chk("busy_after_start", int'(bsa), 1);
    eb = '{4, 7, 7, 3, -1, -5, -8, -8};
    rst_start();
    for (int i = 0; i < 8; i++) begin
      send(1, 2'b01, i < 3, i >= 3, 1'b0);
      chk($sformatf("sat_w0_%0d", i), int'($signed(wb[3:0])), eb[i]);
      chk($sformatf("sat_wb_%0d", i), int'($signed(wb[11:8])), eb[i]);
    end
    chk("sat_w1", int'($signed(wb[7:4])), 0);
    rst_start();
    for (int e = 0; e < 2; e++) begin
      for (int k = 0; k < 4; k++) send(2, 2'(k), k == 3, k != 3, k == 3);
      chk($sformatf("lim_done_e%0d", e), int'(dnc), e);
      chk($sformatf("lim_epoch_e%0d", e), int'(epc), e + 1);
      chk($sformatf("lim_err_e%0d", e), int'(ecc), e == 0 ? 0 : 4);
    end
    chk("lim_conv", int'(cvc), 0);
    @(negedge clk);
    valid[2] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("done_ready_low", int'(rdy[2]), 0);
      chk("done_held", int'(dnc), 1);
    end
    valid[2] = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
